// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX->MEM register, load extract, MEM->WB bus
// Optional ID forwarding port is built only when MEM_BYPASS_EN is defined.
module mem_stage #(
    parameter int EX_TO_MEM_BUS_WD = 75,
    parameter int MEM_TO_WB_BUS_WD = 104
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [EX_TO_MEM_BUS_WD-1:0] EX_to_MEM_bus,
    input  logic                        EX_to_MEM_valid,
    output logic                        MEM_allow_in,
    input  logic [31:0]                 data_sram_rdata,
    output logic [MEM_TO_WB_BUS_WD-1:0] MEM_to_WB_bus,
    output logic                        MEM_to_WB_valid,
    input  logic                        WB_allow_in,
    output logic [38:0]                 MEM_to_ID_fwd
);

    localparam logic [0:0] S_FRESH = 1'b0;
    localparam logic [0:0] S_HELD  = 1'b1;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_LH  = 3'b011;
    localparam logic [2:0] OP_LHU = 3'b100;

    logic                        r_valid;
    logic [EX_TO_MEM_BUS_WD-1:0] r_ex_bus;
    logic [0:0]                  r_state;
    logic [31:0]                 r_rdata_hold;

    logic        w_ready_go;
    logic        w_accept;
    logic [2:0]  w_load_op;
    logic [31:0] w_pc_plus_4;
    logic [31:0] w_alu_res;
    logic [4:0]  w_rf_w_addr;
    logic [1:0]  w_sel_rf_w_data;
    logic        w_sel_rf_w_en;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_ready_go      = 1'b1;
    assign MEM_allow_in    = ~r_valid | (w_ready_go & WB_allow_in);
    assign MEM_to_WB_valid = r_valid & w_ready_go;
    assign w_accept        = EX_to_MEM_valid & MEM_allow_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (MEM_allow_in) begin
            r_valid <= EX_to_MEM_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_bus <= '0;
        end else if (w_accept) begin
            r_ex_bus <= EX_to_MEM_bus;
        end
    end

    // The SRAM word is only valid during the first MEM cycle; capture it if the stage stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_FRESH;
            r_rdata_hold <= 32'd0;
        end else if (w_accept) begin
            r_state <= S_FRESH;
        end else if ((r_state == S_FRESH) && r_valid && !WB_allow_in) begin
            r_state      <= S_HELD;
            r_rdata_hold <= data_sram_rdata;
        end
    end

    assign w_load_op       = r_ex_bus[74:72];
    assign w_pc_plus_4     = r_ex_bus[71:40];
    assign w_alu_res       = r_ex_bus[39:8];
    assign w_rf_w_addr     = r_ex_bus[7:3];
    assign w_sel_rf_w_data = r_ex_bus[2:1];
    assign w_sel_rf_w_en   = r_ex_bus[0];

    assign w_word = (r_state == S_HELD) ? r_rdata_hold : data_sram_rdata;

    always_comb begin
        w_byte = w_word[7:0];
        case (w_alu_res[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    // Halfword select ignores off[0]; misalignment is trapped upstream.
    assign w_half = w_alu_res[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = w_word;
        case (w_load_op)
            OP_LW:   w_load_data = w_word;
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_data = {24'd0, w_byte};
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = w_word;
        endcase
    end

    assign MEM_to_WB_bus = {w_pc_plus_4, w_alu_res, w_load_data,
                            w_rf_w_addr, w_sel_rf_w_data, w_sel_rf_w_en};

`ifdef MEM_BYPASS_EN
    logic        w_fwd_valid;
    logic        w_is_load;
    logic [31:0] w_fwd_data;

    assign w_fwd_valid = r_valid & w_sel_rf_w_en & (w_rf_w_addr != 5'd0);
    assign w_is_load   = (w_sel_rf_w_data == 2'b10);

    // Mirror the value WB will select for the register file write.
    always_comb begin
        w_fwd_data = w_alu_res;
        case (w_sel_rf_w_data)
            2'b10:   w_fwd_data = w_load_data;
            2'b01:   w_fwd_data = w_pc_plus_4 + 32'd4;
            2'b11:   w_fwd_data = 32'd0;
            default: w_fwd_data = w_alu_res;
        endcase
    end

    assign MEM_to_ID_fwd = {w_fwd_valid, w_rf_w_addr, w_fwd_data, w_is_load};
`else
    assign MEM_to_ID_fwd = 39'd0;
`endif

endmodule
